id_ex_stage: RTL and testbench

//  Decode->execute pipeline register. Sits directly downstream of the register file.

---
 rtl/id_ex_pkg.sv | 26 ++
 rtl/id_ex_stage_if.sv | 54 +++++
 rtl/id_ex_stage_load_use_detect.sv | 24 ++
 rtl/id_ex_stage.sv | 119 +++++++++++
 tb/tb_id_ex_stage.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/id_ex_pkg.sv
// Shared types and helpers for the decode->execute pipeline register.
// Holds the execute control bundle layout and the write-back bypass match rule.
package id_ex_pkg;

    localparam int REG_AW = 5;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       alu_src;
        logic       mem_write;
        logic       reg_write;
        logic       branch;
        logic       jump;
        logic [6:0] rsvd;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    // x0 is hard-wired zero, so a write to it must never forward.
    function automatic logic bypass_hit(input logic              we,
                                        input logic [REG_AW-1:0] wrd,
                                        input logic [REG_AW-1:0] rs);
        return we && (wrd != '0) && (wrd == rs);
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode/regfile/write-back/execute signal bundle around the ID/EX register.
// master = surrounding pipeline, slave = the ID/EX stage itself.
interface id_ex_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int PC_W   = 32,
    parameter int CTRL_W = 16
);
    logic              id_valid;
    logic [PC_W-1:0]   id_pc;
    logic [REG_W-1:0]  id_rs1;
    logic [REG_W-1:0]  id_rs2;
    logic              id_rs1_used;
    logic              id_rs2_used;
    logic [REG_W-1:0]  id_rd;
    logic [DATA_W-1:0] id_imm;
    logic [CTRL_W-1:0] id_ctrl;
    logic              id_mem_read;
    logic [DATA_W-1:0] rf_rdata1;
    logic [DATA_W-1:0] rf_rdata2;
    logic              wb_we;
    logic [REG_W-1:0]  wb_rd;
    logic [DATA_W-1:0] wb_wdata;
    logic              ex_ready;
    logic              ex_flush;
    logic              id_stall;
    logic              ex_valid;
    logic [PC_W-1:0]   ex_pc;
    logic [REG_W-1:0]  ex_rs1;
    logic [REG_W-1:0]  ex_rs2;
    logic [REG_W-1:0]  ex_rd;
    logic [DATA_W-1:0] ex_imm;
    logic [CTRL_W-1:0] ex_ctrl;
    logic              ex_mem_read;
    logic [DATA_W-1:0] ex_op1;
    logic [DATA_W-1:0] ex_op2;

    modport master (
        output id_valid, id_pc, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
               id_imm, id_ctrl, id_mem_read, rf_rdata1, rf_rdata2,
               wb_we, wb_rd, wb_wdata, ex_ready, ex_flush,
        input  id_stall, ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_imm, ex_ctrl,
               ex_mem_read, ex_op1, ex_op2
    );

    modport slave (
        input  id_valid, id_pc, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
               id_imm, id_ctrl, id_mem_read, rf_rdata1, rf_rdata2,
               wb_we, wb_rd, wb_wdata, ex_ready, ex_flush,
        output id_stall, ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_imm, ex_ctrl,
               ex_mem_read, ex_op1, ex_op2
    );

endinterface

// File: rtl/id_ex_stage_load_use_detect.sv
// Combinational load-use hazard detect: a load in EX whose rd feeds the
// instruction in ID. Kept standalone so the hazard unit can reuse it.
module load_use_detect #(
    parameter int REG_W = 5
) (
    input  logic             i_ex_valid,
    input  logic             i_ex_mem_read,
    input  logic [REG_W-1:0] i_ex_rd,
    input  logic             i_id_valid,
    input  logic [REG_W-1:0] i_id_rs1,
    input  logic [REG_W-1:0] i_id_rs2,
    input  logic             i_id_rs1_used,
    input  logic             i_id_rs2_used,
    output logic             o_load_use
);
    logic w_rs1_hit;
    logic w_rs2_hit;

    assign w_rs1_hit  = i_id_rs1_used && (i_id_rs1 == i_ex_rd);
    assign w_rs2_hit  = i_id_rs2_used && (i_id_rs2 == i_ex_rd);
    assign o_load_use = i_id_valid && i_ex_valid && i_ex_mem_read &&
                        (i_ex_rd != '0) && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with write-back bypass, load-use bubble, hold and flush.
// Optional ID_EX_PERF_EN adds saturating stall/bubble counters.
module id_ex_stage
    import id_ex_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = REG_AW,
    parameter int PC_W   = 32
) (
    input  logic          clk,
    input  logic          reset,
    id_ex_stage_if.slave  bus
`ifdef ID_EX_PERF_EN
    ,
    output logic [31:0]   perf_stall_cnt,
    output logic [31:0]   perf_bubble_cnt
`endif
);
    logic              r_valid;
    logic [PC_W-1:0]   r_pc;
    logic [REG_W-1:0]  r_rs1;
    logic [REG_W-1:0]  r_rs2;
    logic [REG_W-1:0]  r_rd;
    logic [DATA_W-1:0] r_imm;
    logic [CTRL_W-1:0] r_ctrl;
    logic              r_mem_read;
    logic [DATA_W-1:0] r_op1;
    logic [DATA_W-1:0] r_op2;

    logic              w_load_use;
    logic              w_stall;

    load_use_detect #(.REG_W(REG_W)) u_lud (
        .i_ex_valid    (r_valid),
        .i_ex_mem_read (r_mem_read),
        .i_ex_rd       (r_rd),
        .i_id_valid    (bus.id_valid),
        .i_id_rs1      (bus.id_rs1),
        .i_id_rs2      (bus.id_rs2),
        .i_id_rs1_used (bus.id_rs1_used),
        .i_id_rs2_used (bus.id_rs2_used),
        .o_load_use    (w_load_use)
    );

    // A flush kills the ID slot anyway, so it overrides any stall reason.
    assign w_stall = !reset && !bus.ex_flush && (!bus.ex_ready || w_load_use);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
            r_imm      <= '0;
            r_ctrl     <= '0;
            r_mem_read <= 1'b0;
            r_op1      <= '0;
            r_op2      <= '0;
        end else if (bus.ex_flush) begin
            r_valid <= 1'b0;
        end else if (!bus.ex_ready) begin
            // Held operands still track write-back so they are not stale on release.
            if (bypass_hit(bus.wb_we, bus.wb_rd, r_rs1)) r_op1 <= bus.wb_wdata;
            if (bypass_hit(bus.wb_we, bus.wb_rd, r_rs2)) r_op2 <= bus.wb_wdata;
        end else if (w_load_use) begin
            r_valid <= 1'b0;
        end else begin
            r_valid    <= bus.id_valid;
            r_pc       <= bus.id_pc;
            r_rs1      <= bus.id_rs1;
            r_rs2      <= bus.id_rs2;
            r_rd       <= bus.id_rd;
            r_imm      <= bus.id_imm;
            r_ctrl     <= bus.id_ctrl;
            r_mem_read <= bus.id_mem_read;
            r_op1      <= bypass_hit(bus.wb_we, bus.wb_rd, bus.id_rs1) ? bus.wb_wdata
                                                                       : bus.rf_rdata1;
            r_op2      <= bypass_hit(bus.wb_we, bus.wb_rd, bus.id_rs2) ? bus.wb_wdata
                                                                       : bus.rf_rdata2;
        end
    end

    assign bus.id_stall    = w_stall;
    assign bus.ex_valid    = r_valid;
    assign bus.ex_pc       = r_pc;
    assign bus.ex_rs1      = r_rs1;
    assign bus.ex_rs2      = r_rs2;
    assign bus.ex_rd       = r_rd;
    assign bus.ex_imm      = r_imm;
    assign bus.ex_ctrl     = r_ctrl;
    assign bus.ex_mem_read = r_mem_read;
    assign bus.ex_op1      = r_op1;
    assign bus.ex_op2      = r_op2;

`ifdef ID_EX_PERF_EN
    logic [31:0] r_perf_stall_cnt;
    logic [31:0] r_perf_bubble_cnt;
    logic        w_bubble;

    assign w_bubble = !reset && !bus.ex_flush && bus.ex_ready && w_load_use;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_stall_cnt  <= '0;
            r_perf_bubble_cnt <= '0;
        end else begin
            if (w_stall && (r_perf_stall_cnt != '1))
                r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
            if (w_bubble && (r_perf_bubble_cnt != '1))
                r_perf_bubble_cnt <= r_perf_bubble_cnt + 32'd1;
        end
    end

    assign perf_stall_cnt  = r_perf_stall_cnt;
    assign perf_bubble_cnt = r_perf_bubble_cnt;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; perf checks run when ID_EX_PERF_EN is defined.
module tb_id_ex_stage;
    import id_ex_pkg::*;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    id_ex_stage_if #(.DATA_W(32), .REG_W(5), .PC_W(32), .CTRL_W(CTRL_W)) bus ();

`ifdef ID_EX_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_bubble_cnt;
`endif

    id_ex_stage #(.DATA_W(32), .REG_W(5), .PC_W(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .bus             (bus)
`ifdef ID_EX_PERF_EN
        ,
        .perf_stall_cnt  (perf_stall_cnt),
        .perf_bubble_cnt (perf_bubble_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic defaults();
        bus.id_valid    = 1'b0;
        bus.id_pc       = '0;
        bus.id_rs1      = '0;
        bus.id_rs2      = '0;
        bus.id_rs1_used = 1'b0;
        bus.id_rs2_used = 1'b0;
        bus.id_rd       = '0;
        bus.id_imm      = '0;
        bus.id_ctrl     = '0;
        bus.id_mem_read = 1'b0;
        bus.rf_rdata1   = '0;
        bus.rf_rdata2   = '0;
        bus.wb_we       = 1'b0;
        bus.wb_rd       = '0;
        bus.wb_wdata    = '0;
        bus.ex_ready    = 1'b1;
        bus.ex_flush    = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        defaults();
        reset        = 1'b1;
        bus.id_valid = 1'b1;
        bus.id_pc    = 32'h40;
        bus.rf_rdata1 = 32'h1234;
        bus.ex_ready = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (bus.ex_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0h exp=0", bus.ex_valid); end
        total++; if (bus.ex_op1 !== 32'h0) begin bad++; $display("FAIL reset_op1 got=%0h exp=0", bus.ex_op1); end
        total++; if (bus.ex_pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%0h exp=0", bus.ex_pc); end
        total++; if (bus.id_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0h exp=0", bus.id_stall); end
        reset = 1'b0;
        defaults();
    endtask

    task automatic test_bypass();
        @(negedge clk);
        defaults();
        bus.id_valid = 1'b1; bus.id_pc = 32'h100;
        bus.id_rs1 = 5'd5; bus.id_rs1_used = 1'b1; bus.id_rs2 = 5'd6; bus.id_rs2_used = 1'b1;
        bus.rf_rdata1 = 32'h11; bus.rf_rdata2 = 32'h22;
        bus.wb_we = 1'b1; bus.wb_rd = 5'd5; bus.wb_wdata = 32'hAB;
        @(negedge clk);
        total++; if (bus.ex_op1 !== 32'hAB) begin bad++; $display("FAIL byp_op1_hit got=%0h exp=ab", bus.ex_op1); end
        total++; if (bus.ex_op2 !== 32'h22) begin bad++; $display("FAIL byp_op2_miss got=%0h exp=22", bus.ex_op2); end
        total++; if (bus.ex_valid !== 1'b1) begin bad++; $display("FAIL byp_valid got=%0h exp=1", bus.ex_valid); end
        total++; if (bus.ex_rs1 !== 5'd5) begin bad++; $display("FAIL byp_rs1 got=%0h exp=5", bus.ex_rs1); end
        bus.wb_rd = 5'd0;
        bus.id_rs1 = 5'd0;
        @(negedge clk);
        total++; if (bus.ex_op1 !== 32'h11) begin bad++; $display("FAIL byp_x0 got=%0h exp=11", bus.ex_op1); end
        bus.id_rs1 = 5'd5;
        bus.wb_rd = 5'd6; bus.wb_wdata = 32'hCD;
        @(negedge clk);
        total++; if (bus.ex_op2 !== 32'hCD) begin bad++; $display("FAIL byp_op2_hit got=%0h exp=cd", bus.ex_op2); end
        total++; if (bus.ex_op1 !== 32'h11) begin bad++; $display("FAIL byp_op1_other got=%0h exp=11", bus.ex_op1); end
        bus.wb_we = 1'b0; bus.wb_rd = 5'd5;
        @(negedge clk);
        total++; if (bus.ex_op1 !== 32'h11) begin bad++; $display("FAIL byp_we0 got=%0h exp=11", bus.ex_op1); end
        defaults();
    endtask

    task automatic test_load_use();
        @(negedge clk);
        defaults();
        bus.id_valid = 1'b1; bus.id_pc = 32'h200; bus.id_rd = 5'd3; bus.id_mem_read = 1'b1;
        bus.id_rs1 = 5'd1; bus.id_rs1_used = 1'b1;
        @(negedge clk);
        bus.id_pc = 32'h204; bus.id_mem_read = 1'b0; bus.id_rd = 5'd4;
        bus.id_rs1 = 5'd2; bus.id_rs2 = 5'd3; bus.id_rs2_used = 1'b1;
        bus.rf_rdata1 = 32'h5; bus.rf_rdata2 = 32'h77;
        #1;
        total++; if (bus.id_stall !== 1'b1) begin bad++; $display("FAIL lu_stall got=%0h exp=1", bus.id_stall); end
        @(negedge clk);
        total++; if (bus.ex_valid !== 1'b0) begin bad++; $display("FAIL lu_bubble got=%0h exp=0", bus.ex_valid); end
        bus.wb_we = 1'b1; bus.wb_rd = 5'd3; bus.wb_wdata = 32'h99;
        #1;
        total++; if (bus.id_stall !== 1'b0) begin bad++; $display("FAIL lu_one_bubble got=%0h exp=0", bus.id_stall); end
        @(negedge clk);
        total++; if (bus.ex_valid !== 1'b1) begin bad++; $display("FAIL lu_cap_valid got=%0h exp=1", bus.ex_valid); end
        total++; if (bus.ex_pc !== 32'h204) begin bad++; $display("FAIL lu_cap_pc got=%0h exp=204", bus.ex_pc); end
        total++; if (bus.ex_op2 !== 32'h99) begin bad++; $display("FAIL lu_cap_op2 got=%0h exp=99", bus.ex_op2); end
        total++; if (bus.ex_op1 !== 32'h5) begin bad++; $display("FAIL lu_cap_op1 got=%0h exp=5", bus.ex_op1); end
        // load to x0 must not stall
        defaults();
        bus.id_valid = 1'b1; bus.id_rd = 5'd0; bus.id_mem_read = 1'b1;
        @(negedge clk);
        bus.id_mem_read = 1'b0; bus.id_rs1 = 5'd0; bus.id_rs1_used = 1'b1; bus.id_rd = 5'd9;
        #1;
        total++; if (bus.id_stall !== 1'b0) begin bad++; $display("FAIL lu_x0 got=%0h exp=0", bus.id_stall); end
        // matching load but empty decode slot must not stall
        @(negedge clk);
        bus.id_rd = 5'd3; bus.id_mem_read = 1'b1; bus.id_rs1_used = 1'b0;
        @(negedge clk);
        bus.id_valid = 1'b0; bus.id_mem_read = 1'b0; bus.id_rs1 = 5'd3; bus.id_rs1_used = 1'b1;
        #1;
        total++; if (bus.id_stall !== 1'b0) begin bad++; $display("FAIL lu_idle got=%0h exp=0", bus.id_stall); end
        defaults();
    endtask

    task automatic test_hold();
        @(negedge clk);
        defaults();
        bus.id_valid = 1'b1; bus.id_pc = 32'h300; bus.id_rs1 = 5'd7; bus.id_rs1_used = 1'b1;
        bus.id_rd = 5'd8; bus.rf_rdata1 = 32'h10; bus.id_imm = 32'h1234; bus.id_ctrl = 16'hABCD;
        @(negedge clk);
        total++; if (bus.ex_op1 !== 32'h10) begin bad++; $display("FAIL hold_cap_op1 got=%0h exp=10", bus.ex_op1); end
        bus.ex_ready = 1'b0;
        bus.id_pc = 32'h304; bus.id_rs1 = 5'd9; bus.rf_rdata1 = 32'hEE; bus.id_imm = 32'h0;
        for (int i = 0; i < 3; i++) begin
            bus.wb_we = (i == 1); bus.wb_rd = 5'd7; bus.wb_wdata = 32'h55;
            #1;
            total++; if (bus.id_stall !== 1'b1) begin bad++; $display("FAIL hold_stall%0d got=%0h exp=1", i, bus.id_stall); end
            @(negedge clk);
            total++; if (bus.ex_pc !== 32'h300) begin bad++; $display("FAIL hold_pc%0d got=%0h exp=300", i, bus.ex_pc); end
        end
        bus.wb_we = 1'b0;
        total++; if (bus.ex_op1 !== 32'h55) begin bad++; $display("FAIL hold_byp got=%0h exp=55", bus.ex_op1); end
        total++; if (bus.ex_imm !== 32'h1234) begin bad++; $display("FAIL hold_imm got=%0h exp=1234", bus.ex_imm); end
        total++; if (bus.ex_ctrl !== 16'hABCD) begin bad++; $display("FAIL hold_ctrl got=%0h exp=abcd", bus.ex_ctrl); end
        total++; if (bus.ex_valid !== 1'b1) begin bad++; $display("FAIL hold_valid got=%0h exp=1", bus.ex_valid); end
        bus.ex_ready = 1'b1;
        @(negedge clk);
        total++; if (bus.ex_pc !== 32'h304) begin bad++; $display("FAIL hold_release_pc got=%0h exp=304", bus.ex_pc); end
        total++; if (bus.ex_op1 !== 32'hEE) begin bad++; $display("FAIL hold_release_op1 got=%0h exp=ee", bus.ex_op1); end
        defaults();
    endtask

    task automatic test_flush();
        @(negedge clk);
        defaults();
        bus.id_valid = 1'b1; bus.id_rd = 5'd3; bus.id_mem_read = 1'b1;
        @(negedge clk);
        bus.id_mem_read = 1'b0; bus.id_rd = 5'd4; bus.id_rs1 = 5'd3; bus.id_rs1_used = 1'b1;
        bus.ex_ready = 1'b0; bus.ex_flush = 1'b1;
        #1;
        total++; if (bus.id_stall !== 1'b0) begin bad++; $display("FAIL flush_stall got=%0h exp=0", bus.id_stall); end
        @(negedge clk);
        total++; if (bus.ex_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%0h exp=0", bus.ex_valid); end
        defaults();
    endtask

`ifdef ID_EX_PERF_EN
    task automatic test_perf();
        @(negedge clk);
        defaults();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bus.id_valid = 1'b1; bus.id_rd = 5'd3; bus.id_mem_read = 1'b1;
        @(negedge clk);
        bus.id_mem_read = 1'b0; bus.id_rd = 5'd4; bus.id_rs1 = 5'd3; bus.id_rs1_used = 1'b1;
        bus.ex_ready = 1'b0;
        repeat (3) @(negedge clk);
        bus.ex_ready = 1'b1;
        @(negedge clk);
        bus.id_valid = 1'b0;
        total++; if (perf_stall_cnt !== 32'd4) begin bad++; $display("FAIL perf_stall got=%0d exp=4", perf_stall_cnt); end
        total++; if (perf_bubble_cnt !== 32'd1) begin bad++; $display("FAIL perf_bubble got=%0d exp=1", perf_bubble_cnt); end
        force dut.r_perf_stall_cnt = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.r_perf_stall_cnt;
        bus.ex_ready = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (perf_stall_cnt !== 32'hFFFF_FFFF) begin bad++; $display("FAIL perf_sat got=%0h exp=ffffffff", perf_stall_cnt); end
        defaults();
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        defaults();
        test_reset();
        test_bypass();
        test_load_use();
        test_hold();
        test_flush();
`ifdef ID_EX_PERF_EN
        test_perf();
`endif
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
